// File: rtl/sr_excite_driver_pkg.sv
// Shared types for the SR excitation driver: FSM state encoding and SR codes.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Holds the state typedef used by sr_excite_driver and the per-bit {s,r}
// excitation codes. The forbidden code 2'b11 is deliberately never produced.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ERR   = 2'd3
  } state_t;

  // {s, r} excitation pair for one SR flip-flop
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;

  // Code needed to move one bit from its believed value to the target value.
  function automatic logic [1:0] sr_code(input logic tgt, input logic cur);
    if (tgt && !cur) begin
      return SR_SET;
    end else if (!tgt && cur) begin
      return SR_RST;
    end else begin
      return SR_HOLD;
    end
  endfunction

endpackage

// File: rtl/sr_excite_driver_if.sv
// Request channel into the SR excitation driver (valid/ready).
// Latency: n/a (wiring only).
// Backpressure: the slave holds tgt_ready low while a request is in flight.
//
// Signals: tgt_data (requested SR bank state), tgt_valid, tgt_ready.
// master = requester, slave = sr_excite_driver.
interface sr_excite_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_valid;
  logic             tgt_ready;

  modport master (output tgt_data, output tgt_valid, input tgt_ready);
  modport slave  (input tgt_data, input tgt_valid, output tgt_ready);
endinterface

// File: rtl/sr_excite_driver_calc.sv
// Per-bit mapping from (target, shadow) to set/reset excitation.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: tgt, shadow in; s, r excitation vectors out; changed = any bit differs.
// A bit is set where the target is 1 and believed 0, reset where the
// target is 0 and believed 1; s and r are never both high on one bit.
module sr_excite_calc
  import sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             changed
);

  always_comb begin
    s       = '0;
    r       = '0;
    changed = |(tgt ^ shadow);
    for (int i = 0; i < WIDTH; i++) begin
      {s[i], r[i]} = sr_code(tgt[i], shadow[i]);
    end
  end

endmodule

// File: rtl/sr_excite_driver.sv
// Drives a bank of SR flip-flops to a requested state with one-cycle set/reset pulses.
// Latency: accept->done 1 cycle if unchanged, 2 with a change (2+SETTLE with readback).
// Backpressure: tgt_ready is high only in IDLE; one request in flight at a time.
//
// Ports: clk, rst (sync, active-high); tgt (request interface, slave);
//   s_out/r_out excitation; q_fb readback; done pulse; err/err_bits sticky
//   mismatch report; err_clr; xfer_cnt completed-request counter (wraps).
// Build option: define SR_EXCITE_READBACK_EN to add the CHECK/ERR readback
//   compare. Without it q_fb/err_clr are ignored and err/err_bits are 0.
module sr_excite_driver
  import sr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  sr_excite_driver_if.slave tgt,
  output logic [WIDTH-1:0]  s_out,
  output logic [WIDTH-1:0]  r_out,
  input  logic [WIDTH-1:0]  q_fb,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  err_bits,
  input  logic              err_clr,
  output logic [15:0]       xfer_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] s_calc;
  logic [WIDTH-1:0] r_calc;
  logic             changed;
  logic             accept;
  logic             finish;
  logic             mismatch;
  logic             clear_err;

`ifdef SR_EXCITE_READBACK_EN
  logic [3:0]       settle_cnt;
`else
  logic             unused_readback;
  assign unused_readback = ^{q_fb, err_clr, 4'(SETTLE)};
  assign err      = 1'b0;
  assign err_bits = '0;
`endif

  sr_excite_calc #(.WIDTH(WIDTH)) u_calc (
    .tgt     (tgt.tgt_data),
    .shadow  (shadow),
    .s       (s_calc),
    .r       (r_calc),
    .changed (changed)
  );

  assign tgt.tgt_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    mismatch  = 1'b0;
    clear_err = 1'b0;
    case (state)
      IDLE: begin
        if (tgt.tgt_valid) begin
          accept = 1'b1;
          if (changed) begin
            state_nxt = DRIVE;
          end else begin
            finish = 1'b1;
          end
        end
      end
      DRIVE: begin
`ifdef SR_EXCITE_READBACK_EN
        state_nxt = CHECK;
`else
        state_nxt = IDLE;
        finish    = 1'b1;
`endif
      end
`ifdef SR_EXCITE_READBACK_EN
      CHECK: begin
        if (settle_cnt == 4'd0) begin
          if (q_fb == shadow) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            mismatch  = 1'b1;
            state_nxt = ERR;
          end
        end
      end
      ERR: begin
        if (err_clr) begin
          clear_err = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      s_out    <= '0;
      r_out    <= '0;
      done     <= 1'b0;
      xfer_cnt <= 16'd0;
`ifdef SR_EXCITE_READBACK_EN
      settle_cnt <= 4'd0;
      err        <= 1'b0;
      err_bits   <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= finish;
      // excitation is a single-cycle pulse: cleared every cycle unless loading
      s_out <= '0;
      r_out <= '0;
      if (accept && changed) begin
        s_out <= s_calc;
        r_out <= r_calc;
      end
      if (finish) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      // applying the pulse to the shadow yields exactly the accepted target
      if (state == DRIVE) begin
        shadow <= (shadow & ~r_out) | s_out;
      end
`ifdef SR_EXCITE_READBACK_EN
      if (state == DRIVE) begin
        settle_cnt <= 4'(SETTLE - 1);
      end else if (state == CHECK && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (mismatch) begin
        err      <= 1'b1;
        err_bits <= q_fb ^ shadow;
      end
      // resynchronise belief to the real bank when leaving ERR
      if (clear_err) begin
        err      <= 1'b0;
        err_bits <= '0;
        shadow   <= q_fb;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sr_excite_driver.sv
// Self-checking bench for sr_excite_driver (WIDTH=8, SETTLE=1), either build.
// Latency: n/a.  Backpressure: requests are issued only while tgt_ready is sampled.
module tb_sr_excite_driver;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 1;
`ifdef SR_EXCITE_READBACK_EN
  localparam int LAT_CHG = 2 + SETTLE;
`else
  localparam int LAT_CHG = 2;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] s_out, r_out, q_fb, err_bits;
  logic             done, err, err_clr;
  logic [15:0]      xfer_cnt;
  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] stuck0;

  int               vectors    = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] m_shadow;
  logic [15:0]      m_cnt;

  sr_excite_driver_if #(.WIDTH(WIDTH)) tgt_if ();

  sr_excite_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt      (tgt_if),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_fb     (q_fb),
    .done     (done),
    .err      (err),
    .err_bits (err_bits),
    .err_clr  (err_clr),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // physical SR bank: set/reset on the clock, cleared with the block reset
  always @(posedge clk) begin
    if (rst) bank <= '0;
    else     bank <= (bank & ~r_out) | s_out;
  end
  assign q_fb = bank & ~stuck0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Issue one request from a negedge; observe until done or 20 cycles.
  task automatic run_req(input logic [WIDTH-1:0] data, output int lat,
                         output logic [WIDTH-1:0] s_seen, output logic [WIDTH-1:0] r_seen,
                         output int exc_cyc, output bit overlap,
                         output logic done_after, output logic rdy0);
    int n;
    lat = 0; s_seen = '0; r_seen = '0; exc_cyc = 0; overlap = 0; done_after = 1'b0;
    tgt_if.tgt_data  = data;
    tgt_if.tgt_valid = 1'b1;
    rdy0 = tgt_if.tgt_ready;
    @(posedge clk);
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    n = 1;
    while (lat == 0 && n <= 20) begin
      if ((s_out | r_out) != '0) begin
        exc_cyc++;
        s_seen = s_out;
        r_seen = r_out;
      end
      if ((s_out & r_out) != '0) overlap = 1;
      if (done === 1'b1) lat = n;
      @(negedge clk);
      n++;
    end
    if (lat != 0) done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; err_clr = 1'b0; stuck0 = '0;
    tgt_if.tgt_valid = 1'b0; tgt_if.tgt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s_out, r_out, done, err, err_bits, xfer_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: s=%h r=%h done=%b err=%b err_bits=%h cnt=%h, required all 0",
               s_out, r_out, done, err, err_bits, xfer_cnt);
    end
    vectors++;
    if (tgt_if.tgt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 1", tgt_if.tgt_ready);
    end
    m_shadow = '0;
    m_cnt    = '0;
  endtask

  // Directed 0xA5, 0x5A, 0x5A first, then randomized requests with frequent repeats.
  task automatic test_requests;
    logic [WIDTH-1:0] tbl [3] = '{8'hA5, 8'h5A, 8'h5A};
    logic [WIDTH-1:0] data, exp_s, exp_r, s_seen, r_seen;
    int lat, exc_cyc, exp_lat;
    bit overlap, chg;
    logic done_after, rdy0;
    for (int i = 0; i < 43; i++) begin
      if (i < 3) data = tbl[i];
      else if ($urandom_range(0, 2) == 0) data = m_shadow;
      else data = WIDTH'($urandom);
      chg     = (data != m_shadow);
      exp_lat = chg ? LAT_CHG : 1;
      exp_s   = chg ? (data & ~m_shadow) : '0;
      exp_r   = chg ? (~data & m_shadow) : '0;
      run_req(data, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
      m_shadow = data;
      m_cnt    = m_cnt + 16'd1;
      vectors++;
      if (rdy0 !== 1'b1) begin
        miscompares++;
        $display("FAIL req%0d_ready: got %b, required 1", i, rdy0);
      end
      vectors++;
      if (lat != exp_lat) begin
        miscompares++;
        $display("FAIL req%0d_latency data=%h: got %0d, required %0d", i, data, lat, exp_lat);
      end
      vectors++;
      if (exc_cyc != (chg ? 1 : 0) || s_seen !== exp_s || r_seen !== exp_r) begin
        miscompares++;
        $display("FAIL req%0d_excite: cycles=%0d s=%h r=%h, required cycles=%0d s=%h r=%h",
                 i, exc_cyc, s_seen, r_seen, chg ? 1 : 0, exp_s, exp_r);
      end
      vectors++;
      if (overlap) begin
        miscompares++;
        $display("FAIL req%0d_forbidden_11: got s&r nonzero, required 0", i);
      end
      vectors++;
      if (done_after !== 1'b0) begin
        miscompares++;
        $display("FAIL req%0d_done_pulse: got done=%b after pulse, required 0", i, done_after);
      end
      vectors++;
      if (xfer_cnt !== m_cnt || err !== 1'b0) begin
        miscompares++;
        $display("FAIL req%0d_count: cnt=%h err=%b, required cnt=%h err=0", i, xfer_cnt, err, m_cnt);
      end
    end
  endtask

  task automatic test_readback;
    logic [WIDTH-1:0] s_seen, r_seen;
    int lat, exc_cyc;
    bit overlap;
    logic done_after, rdy0;
`ifdef SR_EXCITE_READBACK_EN
    int n;
    bit seen_done;
    run_req(8'h00, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
    m_shadow = 8'h00; m_cnt = m_cnt + 16'd1;
    stuck0 = 8'h08;
    tgt_if.tgt_data = 8'hFF; tgt_if.tgt_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    n = 0; seen_done = 0;
    while (err !== 1'b1 && n < 10) begin
      if (done === 1'b1) seen_done = 1;
      @(negedge clk); n++;
    end
    vectors++;
    if (err !== 1'b1 || err_bits !== 8'h08 || seen_done) begin
      miscompares++;
      $display("FAIL stuck_err: err=%b err_bits=%h done_seen=%b, required err=1 err_bits=08 done_seen=0",
               err, err_bits, seen_done);
    end
    // err_clr is only honoured in ERR; hold here a few cycles first
    repeat (3) @(negedge clk);
    vectors++;
    if (tgt_if.tgt_ready !== 1'b0 || err !== 1'b1 || xfer_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL err_hold: ready=%b err=%b cnt=%h, required ready=0 err=1 cnt=%h",
               tgt_if.tgt_ready, err, xfer_cnt, m_cnt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0 || err_bits !== '0 || tgt_if.tgt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: err=%b err_bits=%h ready=%b, required 0 00 1",
               err, err_bits, tgt_if.tgt_ready);
    end
    // shadow now holds the real bank value 0xF7, so this request is a no-op
    run_req(8'hF7, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
    m_shadow = 8'hF7; m_cnt = m_cnt + 16'd1;
    vectors++;
    if (lat != 1 || exc_cyc != 0 || xfer_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL resync: lat=%0d exc=%0d cnt=%h, required lat=1 exc=0 cnt=%h",
               lat, exc_cyc, xfer_cnt, m_cnt);
    end
    // reset and err_clr together: reset wins, shadow becomes 0 rather than q_fb
    tgt_if.tgt_data = 8'hFF; tgt_if.tgt_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_err2: got err=%b, required 1", err);
    end
    rst = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; err_clr = 1'b0; stuck0 = '0;
    m_shadow = '0; m_cnt = '0;
    run_req(8'h00, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
    m_cnt = m_cnt + 16'd1;
    vectors++;
    if (lat != 1 || err !== 1'b0 || xfer_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL rst_over_errclr: lat=%0d err=%b cnt=%h, required lat=1 err=0 cnt=%h",
               lat, err, xfer_cnt, m_cnt);
    end
`else
    logic [WIDTH-1:0] d;
    d = ~m_shadow;
    stuck0 = 8'h08;
    run_req(d, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
    m_shadow = d; m_cnt = m_cnt + 16'd1;
    vectors++;
    if (lat != 2 || err !== 1'b0 || err_bits !== '0) begin
      miscompares++;
      $display("FAIL no_readback_lat: lat=%0d err=%b err_bits=%h, required lat=2 err=0 err_bits=00",
               lat, err, err_bits);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || tgt_if.tgt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL no_readback_errclr: err=%b ready=%b, required err=0 ready=1", err, tgt_if.tgt_ready);
    end
    // q_fb disagrees with the shadow, but without readback the shadow rules
    run_req(d, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
    m_cnt = m_cnt + 16'd1;
    vectors++;
    if (lat != 1 || exc_cyc != 0 || xfer_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL no_readback_ignore_q: lat=%0d exc=%0d cnt=%h, required lat=1 exc=0 cnt=%h",
               lat, exc_cyc, xfer_cnt, m_cnt);
    end
    stuck0 = '0;
`endif
  endtask

  task automatic test_rst_in_drive;
    logic [WIDTH-1:0] d, s_seen, r_seen;
    int lat, exc_cyc;
    bit overlap;
    logic done_after, rdy0;
    d = ~m_shadow;
    tgt_if.tgt_data = d; tgt_if.tgt_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (s_out !== (d & ~m_shadow) || r_out !== (~d & m_shadow)) begin
      miscompares++;
      $display("FAIL drive_pulse: s=%h r=%h, required s=%h r=%h", s_out, r_out, d & ~m_shadow, ~d & m_shadow);
    end
    // reset mid-pulse with a pending differing request that must not be taken
    rst = 1'b1;
    tgt_if.tgt_data = 8'h3C;
    @(negedge clk);
    vectors++;
    if ({s_out, r_out, done, err, err_bits, xfer_cnt} !== '0 || tgt_if.tgt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_drive: s=%h r=%h done=%b err=%b cnt=%h ready=%b, required zeros and ready=1",
               s_out, r_out, done, err, xfer_cnt, tgt_if.tgt_ready);
    end
    @(negedge clk);
    rst = 1'b0; tgt_if.tgt_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_out !== '0 || r_out !== '0 || done !== 1'b0 || tgt_if.tgt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_over_valid: s=%h r=%h done=%b ready=%b, required 00 00 0 1",
               s_out, r_out, done, tgt_if.tgt_ready);
    end
    m_shadow = '0; m_cnt = '0;
    run_req(8'h00, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
    m_cnt = m_cnt + 16'd1;
    vectors++;
    if (lat != 1 || xfer_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL rst_shadow_cleared: lat=%0d cnt=%h, required lat=1 cnt=%h", lat, xfer_cnt, m_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [WIDTH-1:0] d, s_seen, r_seen;
    int lat, exc_cyc;
    bit overlap;
    logic done_after, rdy0;
    force dut.xfer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    m_cnt = 16'hFFFF;
    d = ~m_shadow;
    run_req(d, lat, s_seen, r_seen, exc_cyc, overlap, done_after, rdy0);
    m_shadow = d; m_cnt = m_cnt + 16'd1;
    vectors++;
    if (xfer_cnt !== m_cnt || lat != LAT_CHG) begin
      miscompares++;
      $display("FAIL cnt_wrap: cnt=%h lat=%0d, required cnt=%h lat=%0d", xfer_cnt, lat, m_cnt, LAT_CHG);
    end
  endtask

  initial begin
    test_reset();
    test_requests();
    test_readback();
    test_rst_in_drive();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
